// File: rtl/dsp_mem2_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mem2_write_arbiter_pkg
// Description : Shared definitions for the bank II write arbiter. It holds the
//               memory word/address lengths, the capture-ring defaults and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_mem2_write_arbiter_pkg;

  // Memory geometry of the DSP data banks.
  localparam int REG_WORD_LEN  = 16;
  localparam int SRAM_ADDR_LEN = 10;

  // Capture ring and arbitration defaults.
  localparam int CAP_BASE_DEF   = 0;
  localparam int CAP_LEN_DEF    = 256;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_WAIT_DEF   = 8;

  // Arbiter state encoding.
  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : dsp_mem2_write_arbiter_pkg
`default_nettype wire

// File: rtl/dsp_mem2_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dsp_sync_fifo
// Description : Single-clock FIFO with show-ahead read data. Push is ignored
//               when full and pop is ignored when empty.
// Ports       : clk, rst_ni (async, active-low), push_i/push_data_i,
//               pop_i/pop_data_o, full_o, empty_o, count_o
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH) + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [$clog2(DEPTH):0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : dsp_sync_fifo
`default_nettype wire

// File: rtl/dsp_mem2_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mem2_write_arbiter
// Description : Shares the bank II SRAM write port between core stores and the
//               receiver capture stream. Captured samples queue in a small FIFO
//               and drain into a circular region whenever the core is idle; a
//               starvation counter forces a capture slot under sustained stores.
// Ports       : clk, rst (async, active-low)
//               dsp_write_en/addr/data in, dsp_stall out     - core store path
//               cap_valid/cap_data in, cap_ready out          - capture stream
//               ovf_clr in, cap_overflow/cap_drop_cnt out     - drop tracking
//               cap_wr_ptr/cap_wrap out                       - ring position
//               sram_write_en/addr/data out (registered)      - bank II pins
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mem2_write_arbiter
  import dsp_mem2_write_arbiter_pkg::*;
#(
  parameter int DATA_W     = REG_WORD_LEN,
  parameter int ADDR_W     = SRAM_ADDR_LEN,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CAP_BASE   = CAP_BASE_DEF,
  parameter int CAP_LEN    = CAP_LEN_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dsp_write_en,
  input  logic [ADDR_W-1:0] dsp_write_addr,
  input  logic [DATA_W-1:0] dsp_write_data,
  output logic              dsp_stall,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  output logic              cap_ready,
  input  logic              ovf_clr,
  output logic              cap_overflow,
  output logic [7:0]        cap_drop_cnt,
  output logic [ADDR_W-1:0] cap_wr_ptr,
  output logic              cap_wrap,
  output logic              sram_write_en,
  output logic [ADDR_W-1:0] sram_write_addr,
  output logic [DATA_W-1:0] sram_write_data
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST      = ADDR_W'(CAP_LEN - 1);
  localparam logic [ADDR_W-1:0] RING_BASE     = ADDR_W'(CAP_BASE);

  // FIFO interface
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_rd_data;

  // Arbitration
  arb_state_e        state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              grant_core;
  logic              grant_cap;
  logic              cap_denied;

  // Ring pointer and drop tracking
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              wrap_q;
  logic              ovf_q;
  logic              ovf_d;
  logic [7:0]        drop_cnt_q;
  logic [7:0]        drop_cnt_d;
  logic              cap_drop;

  // Registered SRAM write port
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  dsp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cap_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (cap_valid),
    .push_data_i (cap_data),
    .pop_i       (grant_cap),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Readiness and drops come from the registered occupancy only, so a pop in
  // the same cycle never reopens a full FIFO.
  assign cap_ready = !fifo_full;
  assign cap_drop  = cap_valid && (fifo_count == FIFO_FULL_CNT);

  // In FORCE the core is held off for exactly the forced slot.
  assign grant_core = dsp_write_en && (state_q == ARB_NORMAL);
  assign grant_cap  = !fifo_empty && ((state_q == ARB_FORCE) || !dsp_write_en);
  assign cap_denied = !fifo_empty && !grant_cap;
  assign dsp_stall  = dsp_write_en && (state_q == ARB_FORCE);

  assign ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);

  // A drop in the same cycle as a clear restarts the tally at one.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (cap_drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = ovf_clr ? 8'd1 : sat_inc8(drop_cnt_q);
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Arbiter FSM with its starvation counter. The counter saturates at the
  // threshold; the FORCE slot that follows always clears it via the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_NORMAL;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_NORMAL: begin
          if (cap_denied && (wait_cnt_q == WAIT_LAST)) state_q <= ARB_FORCE;
        end
        ARB_FORCE: state_q <= ARB_NORMAL;
        default:   state_q <= ARB_NORMAL;
      endcase
      if (fifo_empty || grant_cap) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_LAST) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  // SRAM port, ring pointer and overflow state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ptr_q      <= '0;
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_en_q <= grant_core || grant_cap;
      if (grant_core) begin
        wr_addr_q <= dsp_write_addr;
        wr_data_q <= dsp_write_data;
      end else if (grant_cap) begin
        wr_addr_q <= RING_BASE + ptr_q;
        wr_data_q <= fifo_rd_data;
      end
      wrap_q <= grant_cap && (ptr_q == PTR_LAST);
      if (grant_cap) ptr_q <= ptr_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cap_overflow    = ovf_q;
  assign cap_drop_cnt    = drop_cnt_q;
  assign cap_wr_ptr      = ptr_q;
  assign cap_wrap        = wrap_q;
  assign sram_write_en   = wr_en_q;
  assign sram_write_addr = wr_addr_q;
  assign sram_write_data = wr_data_q;

endmodule : dsp_mem2_write_arbiter
`default_nettype wire

// File: tb/tb_dsp_mem2_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mem2_write_arbiter
// Description : Directed self-checking bench. Expected SRAM writes are queued
//               per stream (core / capture ring) when stimulus is driven and
//               popped by a monitor when the write appears on the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mem2_write_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int BASE  = 128;
  localparam int LEN   = 4;
  localparam int MW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          dsp_write_en;
  logic [AW-1:0] dsp_write_addr;
  logic [DW-1:0] dsp_write_data;
  logic          dsp_stall;
  logic          cap_valid;
  logic [DW-1:0] cap_data;
  logic          cap_ready;
  logic          ovf_clr;
  logic          cap_overflow;
  logic [7:0]    cap_drop_cnt;
  logic [AW-1:0] cap_wr_ptr;
  logic          cap_wrap;
  logic          sram_write_en;
  logic [AW-1:0] sram_write_addr;
  logic [DW-1:0] sram_write_data;

  always #5 clk = ~clk;

  dsp_mem2_write_arbiter #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .CAP_BASE   (BASE),
    .CAP_LEN    (LEN),
    .MAX_WAIT   (MW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dsp_write_en    (dsp_write_en),
    .dsp_write_addr  (dsp_write_addr),
    .dsp_write_data  (dsp_write_data),
    .dsp_stall       (dsp_stall),
    .cap_valid       (cap_valid),
    .cap_data        (cap_data),
    .cap_ready       (cap_ready),
    .ovf_clr         (ovf_clr),
    .cap_overflow    (cap_overflow),
    .cap_drop_cnt    (cap_drop_cnt),
    .cap_wr_ptr      (cap_wr_ptr),
    .cap_wrap        (cap_wrap),
    .sram_write_en   (sram_write_en),
    .sram_write_addr (sram_write_addr),
    .sram_write_data (sram_write_data)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t cap_q[$];
  wr_t core_q[$];
  int  n_chk     = 0;
  int  n_fail    = 0;
  int  exp_ptr   = 0;
  int  core_k    = 0;
  bit  core_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive phase: 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cap(input logic [DW-1:0] d);
    cap_q.push_back({AW'(BASE + exp_ptr), d});
    exp_ptr = (exp_ptr + 1) % LEN;
  endtask

  // A stalled store is held unchanged; a new store is queued only once.
  task automatic core_drive(input bit en);
    if (en) begin
      if (!core_hold) begin
        core_k++;
        dsp_write_addr = AW'(256 + core_k);
        dsp_write_data = DW'(16'h1000 + core_k);
        core_q.push_back({dsp_write_addr, dsp_write_data});
      end
      dsp_write_en = 1'b1;
    end else begin
      dsp_write_en = 1'b0;
      core_hold    = 1'b0;
    end
  endtask

  task automatic sample_hold();
    core_hold = dsp_write_en && dsp_stall;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((cap_q.size() != 0 || core_q.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, cap_q.size() + core_q.size(), 0);
  endtask

  // Write monitor: classify by address and compare against the stream queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst === 1'b1 && sram_write_en === 1'b1) begin
      if (sram_write_addr >= AW'(BASE) && sram_write_addr < AW'(BASE + LEN)) begin
        chk("cap_write_expected", 32'(cap_q.size() != 0), 1);
        if (cap_q.size() != 0) begin
          e = cap_q.pop_front();
          chk("cap_addr", 32'(sram_write_addr), 32'(e.a));
          chk("cap_data", 32'(sram_write_data), 32'(e.d));
        end
      end else begin
        chk("core_write_expected", 32'(core_q.size() != 0), 1);
        if (core_q.size() != 0) begin
          e = core_q.pop_front();
          chk("core_addr", 32'(sram_write_addr), 32'(e.a));
          chk("core_data", 32'(sram_write_data), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    dsp_write_en   = 1'b0;
    dsp_write_addr = '0;
    dsp_write_data = '0;
    cap_valid      = 1'b0;
    cap_data       = '0;
    ovf_clr        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(sram_write_en), 0);
    chk("rst_wr_addr", 32'(sram_write_addr), 0);
    chk("rst_wr_data", 32'(sram_write_data), 0);
    chk("rst_stall", 32'(dsp_stall), 0);
    chk("rst_ovf", 32'(cap_overflow), 0);
    chk("rst_drop_cnt", 32'(cap_drop_cnt), 0);
    chk("rst_ptr", 32'(cap_wr_ptr), 0);
    chk("rst_wrap", 32'(cap_wrap), 0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(cap_ready), 1);

    // Single core store: written the following cycle
    step();
    dsp_write_en   = 1'b1;
    dsp_write_addr = 10'h010;
    dsp_write_data = 16'hABCD;
    core_q.push_back({10'h010, 16'hABCD});
    #1;
    chk("core_stall", 32'(dsp_stall), 0);
    chk("core_not_yet", 32'(sram_write_en), 0);
    step();
    dsp_write_en = 1'b0;
    #1;
    chk("core_wr_en", 32'(sram_write_en), 1);
    chk("core_wr_addr", 32'(sram_write_addr), 32'h010);
    chk("core_wr_data", 32'(sram_write_data), 32'hABCD);
    repeat (2) step();

    // Capture only: three samples, first write two cycles after the first
    for (int i = 0; i < 6; i++) begin
      step();
      cap_valid = (i < 3);
      cap_data  = DW'(i + 1);
      if (i < 3) push_cap(DW'(i + 1));
      #1;
      chk($sformatf("cap_lat_en_%0d", i), 32'(sram_write_en), 32'(i >= 2 && i <= 4));
      if (i == 2) chk("cap_first_addr", 32'(sram_write_addr), 32'h080);
    end
    cap_valid = 1'b0;
    chk("cap_ptr_3", 32'(cap_wr_ptr), 3);
    drain("cap_drain");

    // Starvation: one sample queued behind continuous stores. It enters the
    // FIFO at cycle 1 and the forced slot (one stall) lands 8 cycles later.
    for (int i = 0; i < 14; i++) begin
      step();
      core_drive(1'b1);
      cap_valid = (i == 0);
      cap_data  = 16'h0055;
      if (i == 0) push_cap(16'h0055);
      #1;
      sample_hold();
      chk($sformatf("starve_stall_%0d", i), 32'(dsp_stall), 32'(i == MW + 1));
      if (i == MW + 2) chk("starve_wrap_pulse", 32'(cap_wrap), 1);
      if (i == MW + 3) chk("starve_wrap_low", 32'(cap_wrap), 0);
    end
    step();
    core_drive(1'b0);
    cap_valid = 1'b0;
    drain("starve_drain");

    // Overflow: 10 samples into a depth-4 FIFO under continuous stores
    for (int i = 0; i < 14; i++) begin
      step();
      core_drive(1'b1);
      cap_valid = (i < 10);
      cap_data  = DW'(16'h0200 + i);
      if (i < 4) push_cap(DW'(16'h0200 + i));
      #1;
      sample_hold();
      if (i == 3) chk("ovf_ready_before_full", 32'(cap_ready), 1);
      if (i == 4) chk("ovf_ready_full", 32'(cap_ready), 0);
    end
    step();
    core_drive(1'b0);
    cap_valid = 1'b0;
    #1;
    chk("ovf_flag", 32'(cap_overflow), 1);
    chk("ovf_drop_cnt", 32'(cap_drop_cnt), 6);
    drain("ovf_drain");
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    #1;
    chk("ovf_clr_flag", 32'(cap_overflow), 0);
    chk("ovf_clr_cnt", 32'(cap_drop_cnt), 0);

    // Wrap: five samples into a 4-word ring starting at offset 0
    chk("wrap_start_ptr", 32'(cap_wr_ptr), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      cap_valid = (i < 5);
      cap_data  = DW'(16'h0300 + i);
      if (i < 5) push_cap(DW'(16'h0300 + i));
      #1;
      chk($sformatf("wrap_pulse_%0d", i), 32'(cap_wrap), 32'(i == 5));
      chk($sformatf("wrap_en_%0d", i), 32'(sram_write_en), 32'(i >= 2 && i <= 6));
    end
    cap_valid = 1'b0;
    chk("wrap_end_ptr", 32'(cap_wr_ptr), 1);
    drain("wrap_drain");

    // Reset mid-drain: three samples held back by continuous stores
    for (int i = 0; i < 4; i++) begin
      step();
      core_drive(1'b1);
      cap_valid = (i < 3);
      cap_data  = DW'(16'h0400 + i);
      if (i < 3) push_cap(DW'(16'h0400 + i));
      #1;
      sample_hold();
    end
    chk("rstmid_wr_active", 32'(sram_write_en), 1);
    rst = 1'b0;
    #1;
    chk("rstmid_wr_dropped", 32'(sram_write_en), 0);
    chk("rstmid_ptr", 32'(cap_wr_ptr), 0);
    dsp_write_en = 1'b0;
    cap_valid    = 1'b0;
    core_hold    = 1'b0;
    cap_q.delete();
    core_q.delete();
    exp_ptr = 0;
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rstmid_no_stale_%0d", i), 32'(sram_write_en), 0);
    end
    chk("rstmid_ptr_after", 32'(cap_wr_ptr), 0);
    chk("rstmid_ready", 32'(cap_ready), 1);
    chk("final_queues_empty", cap_q.size() + core_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dsp_mem2_write_arbiter
`default_nettype wire

// File: doc/dsp_mem2_write_arbiter.md
# dsp_mem2_write_arbiter

Shares the single write port of Data Memory Bank II between the DSP core's store path and the receiver sample-capture stream. Capture samples go into a small FIFO and drain into a circular buffer region of bank II whenever the core is not writing. A starvation counter forces capture slots under sustained core stores. The block sits between the DSP memory logic and the bank II SRAM write pins; the bank II read path bypasses it.

## Interface
- DATA_W, default `REG_WORD_LEN: SRAM word width.
- ADDR_W, default `SRAM_ADDR_LEN: SRAM address width.
- FIFO_DEPTH, default 4: capture FIFO entries (power of two, ≥2).
- CAP_BASE, default 0: first SRAM address of the capture ring.
- CAP_LEN, default 256: ring length in words (CAP_BASE+CAP_LEN ≤ 2^ADDR_W).
- MAX_WAIT, default 8: consecutive denied cycles before a forced capture slot (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dsp_write_en  in  1  core store request.
- dsp_write_addr  in  ADDR_W  core store address.
- dsp_write_data  in  DATA_W  core store data.
- dsp_stall  out  1  core store refused this cycle; core holds request.
- cap_valid  in  1  capture sample present (front end cannot stall).
- cap_data  in  DATA_W  capture sample.
- cap_ready  out  1  FIFO not full.
- ovf_clr  in  1  clears overflow flag and drop count.
- cap_overflow  out  1  sticky: a sample was dropped.
- cap_drop_cnt  out  8  dropped samples, saturating at 255.
- cap_wr_ptr  out  ADDR_W  next ring offset (0..CAP_LEN-1).
- cap_wrap  out  1  one-cycle pulse when ring pointer wraps.
- sram_write_en  out  1  bank II write enable (registered).
- sram_write_addr  out  ADDR_W  bank II write address (registered).
- sram_write_data  out  DATA_W  bank II write data (registered).

## Operation
- FIFO push when cap_valid && cap_ready. If cap_valid && !cap_ready, the sample is dropped, cap_overflow sets, and cap_drop_cnt increments and saturates at 255.
- cap_ready = !full, computed from the registered count. A pop in the same cycle does not reopen a full FIFO.
- Arbiter FSM, states NORMAL and FORCE:
  - NORMAL: dsp_write_en grants the core. Otherwise, a non-empty FIFO grants a pop.
  - FORCE: a non-empty FIFO is granted unconditionally. dsp_stall = dsp_write_en. Always returns to NORMAL next cycle.
- wait_cnt counts cycles with the FIFO non-empty and capture not granted. It clears on a capture grant or when the FIFO is empty. When wait_cnt reaches MAX_WAIT-1 and capture is denied again, the FSM goes NORMAL→FORCE.
- Capture write address = CAP_BASE + cap_wr_ptr. The pointer increments per pop and wraps CAP_LEN-1→0 with a cap_wrap pulse.
- ovf_clr and a new drop in the same cycle: the drop wins (flag = 1, count = 1).
- dsp_stall depends combinationally on dsp_write_en and the registered state only.

## Timing
- Reset (rst=0, async): FSM=NORMAL, FIFO empty, wait_cnt=0, cap_wr_ptr=0, cap_overflow=0, cap_drop_cnt=0, cap_wrap=0, sram_write_en=0, sram_write_addr=0, sram_write_data=0, dsp_stall=0. cap_ready=1 after release.
- Core store granted at cycle N: SRAM write at N+1.
- Sample accepted at N into an empty FIFO, with the port free: pop at N+1, SRAM write at N+2.
- Sustained core stores: a capture slot occurs at most every MAX_WAIT+1 cycles.
- Reset mid-operation discards FIFO contents. A registered SRAM write is deasserted immediately.

## Structure
- Add FSM state encoding and the CAP_* defaults to definitions.v, next to the existing memory length macros.
- One sub-module: dsp_sync_fifo (parameterised width/depth, push/pop, full/empty, count).

## Test plan
- Core store only: dsp_write_en=1, addr=0x10, data=0xABCD, single cycle → sram_write_en=1, addr 0x10, data 0xABCD the next cycle; dsp_stall=0.
- Capture only: 3 samples 1,2,3 on consecutive cycles, CAP_BASE=0x80 → writes to 0x80,0x81,0x82 starting 2 cycles after the first; cap_wr_ptr=3.
- Starvation, MAX_WAIT=8: core stores every cycle and one queued sample → dsp_stall=1 for exactly one cycle, 8 cycles after the sample; the sample is written in that slot.
- Overflow: core stores every cycle, MAX_WAIT=8 and FIFO_DEPTH=4, with 10 samples on consecutive cycles → 4 accepted, 6 dropped; cap_overflow=1, cap_drop_cnt=6. Then pulse ovf_clr → both reach 0.
- Wrap: CAP_LEN=4, 5 samples → addresses CAP_BASE+0,1,2,3,0; cap_wrap pulses with the 4th pop.
- Reset mid-drain: assert rst with 3 samples queued → sram_write_en drops immediately; after release no stale write and cap_wr_ptr=0.
